// File: rtl/bg_line_collector.sv
// Resolves the front-most opaque background per column from the BG packet stream into a
// ping-pong line buffer. Optional second-layer tracking: define BG_SECOND_LAYER_EN.
module bg_line_collector #(
  parameter int unsigned WIDTH = 240,
  parameter int unsigned PW    = 20
) (
  input  logic          clock,
  input  logic          rst_b,
  input  logic [PW-1:0] bg_packet,
  input  logic [7:0]    hcount,
  input  logic          row_start,
  input  logic          swap,
  input  logic          rd_en,
  input  logic [7:0]    rd_addr,
  output logic [20:0]   rd_data,
`ifdef BG_SECOND_LAYER_EN
  output logic [20:0]   rd_second,
`endif
  output logic [7:0]    wr_count,
  output logic          line_ready
);

  localparam logic [7:0] WidthC = 8'(WIDTH);

  typedef struct packed {
    logic [1:0]  bgno;
    logic [1:0]  prio;
    logic        direct;
    logic [14:0] color;
  } entry_t;

  logic [1:0]       phase_q, phase_d, cur_phase;
  entry_t           pkt;
  logic             pkt_v;
  entry_t           cand_q, cand_d;
  logic             cand_v_q, cand_v_d;
  logic             commit;
  logic             wr_bank_q, wr_bank_d, rd_bank;
  logic [7:0]       wr_count_q, wr_count_d;
  logic             line_ready_q;
  logic [20:0]      rd_data_q, rd_data_d;
  logic [WIDTH-1:0] valid_q [2];
  logic [WIDTH-1:0] valid_d [2];
  entry_t           mem_q [2][WIDTH];

`ifdef BG_SECOND_LAYER_EN
  entry_t           sec_q, sec_d;
  logic             sec_v_q, sec_v_d;
  logic [20:0]      mem2_q [2][WIDTH];
  logic [20:0]      rd_second_q, rd_second_d;
`endif

  assign rd_bank = ~wr_bank_q;

  // Candidate resolution; the phase-3 packet is folded in combinationally before commit.
  always_comb begin
    cur_phase   = row_start ? 2'd0 : phase_q;
    phase_d     = cur_phase + 2'd1;
    pkt_v       = bg_packet[19] & ~bg_packet[18];
    pkt.bgno    = cur_phase;
    pkt.prio    = bg_packet[17:16];
    pkt.direct  = bg_packet[15];
    pkt.color   = bg_packet[14:0];
    cand_d      = cand_q;
    cand_v_d    = cand_v_q;
`ifdef BG_SECOND_LAYER_EN
    sec_d       = sec_q;
    sec_v_d     = sec_v_q;
`endif
    if (cur_phase == 2'd0) begin
      cand_d   = pkt;
      cand_v_d = pkt_v;
`ifdef BG_SECOND_LAYER_EN
      sec_d    = '0;
      sec_v_d  = 1'b0;
`endif
    end else if (pkt_v) begin
      // Strict less-than: ties keep the earlier (lower) bgno.
      if (!cand_v_q || (pkt.prio < cand_q.prio)) begin
`ifdef BG_SECOND_LAYER_EN
        sec_d   = cand_q;
        sec_v_d = cand_v_q;
`endif
        cand_d   = pkt;
        cand_v_d = 1'b1;
      end
`ifdef BG_SECOND_LAYER_EN
      else if (!sec_v_q || (pkt.prio < sec_q.prio)) begin
        sec_d   = pkt;
        sec_v_d = 1'b1;
      end
`endif
    end
    commit = (cur_phase == 2'd3) && (hcount < WidthC);
  end

  always_comb begin
    wr_bank_d  = wr_bank_q ^ swap;
    wr_count_d = wr_count_q;
    if (swap) begin
      wr_count_d = '0;
    end else if (commit && (wr_count_q < WidthC)) begin
      wr_count_d = wr_count_q + 8'd1;
    end
    valid_d = valid_q;
    // A coincident commit targets the old write bank, so it never meets the clear.
    if (commit) valid_d[wr_bank_q][hcount] = cand_v_d;
    if (swap)   valid_d[rd_bank] = '0;
  end

  always_comb begin
    rd_data_d = rd_data_q;
`ifdef BG_SECOND_LAYER_EN
    rd_second_d = rd_second_q;
`endif
    if (rd_en) begin
      rd_data_d = '0;
`ifdef BG_SECOND_LAYER_EN
      rd_second_d = '0;
`endif
      if ((rd_addr < WidthC) && valid_q[rd_bank][rd_addr]) begin
        rd_data_d = {1'b1, mem_q[rd_bank][rd_addr]};
`ifdef BG_SECOND_LAYER_EN
        rd_second_d = mem2_q[rd_bank][rd_addr];
`endif
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_b) begin
      phase_q      <= '0;
      cand_q       <= '0;
      cand_v_q     <= 1'b0;
      wr_bank_q    <= 1'b0;
      wr_count_q   <= '0;
      line_ready_q <= 1'b0;
      rd_data_q    <= '0;
      valid_q[0]   <= '0;
      valid_q[1]   <= '0;
`ifdef BG_SECOND_LAYER_EN
      sec_q        <= '0;
      sec_v_q      <= 1'b0;
      rd_second_q  <= '0;
`endif
    end else begin
      phase_q      <= phase_d;
      cand_q       <= cand_d;
      cand_v_q     <= cand_v_d;
      wr_bank_q    <= wr_bank_d;
      wr_count_q   <= wr_count_d;
      line_ready_q <= swap;
      rd_data_q    <= rd_data_d;
      valid_q[0]   <= valid_d[0];
      valid_q[1]   <= valid_d[1];
`ifdef BG_SECOND_LAYER_EN
      sec_q        <= sec_d;
      sec_v_q      <= sec_v_d;
      rd_second_q  <= rd_second_d;
`endif
    end
  end

  // Line storage carries no reset; per-entry valid bits gate every read.
  always_ff @(posedge clock) begin
    if (rst_b && commit) begin
      mem_q[wr_bank_q][hcount] <= cand_d;
`ifdef BG_SECOND_LAYER_EN
      mem2_q[wr_bank_q][hcount] <= sec_v_d ? {1'b1, sec_d} : 21'd0;
`endif
    end
  end

  assign rd_data    = rd_data_q;
  assign wr_count   = wr_count_q;
  assign line_ready = line_ready_q;
`ifdef BG_SECOND_LAYER_EN
  assign rd_second  = rd_second_q;
`endif

endmodule

// File: tb/tb_bg_line_collector.sv
// Scoreboard bench for bg_line_collector: reads push expected words, a monitor pops and compares.
module tb_bg_line_collector;

  logic        clock;
  logic        rst_b;
  logic [19:0] bg_packet;
  logic [7:0]  hcount;
  logic        row_start;
  logic        swap;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [20:0] rd_data;
  logic [7:0]  wr_count;
  logic        line_ready;
`ifdef BG_SECOND_LAYER_EN
  logic [20:0] rd_second;
`endif

  int checks   = 0;
  int failures = 0;

  logic [20:0] exp_q [$];
  logic [20:0] exp2_q [$];
  logic        rd_pend;

  bg_line_collector dut (
    .clock      (clock),
    .rst_b      (rst_b),
    .bg_packet  (bg_packet),
    .hcount     (hcount),
    .row_start  (row_start),
    .swap       (swap),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
`ifdef BG_SECOND_LAYER_EN
    .rd_second  (rd_second),
`endif
    .wr_count   (wr_count),
    .line_ready (line_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [19:0] pk(logic u, logic t, logic [1:0] p, logic d, logic [14:0] c);
    return {u, t, p, d, c};
  endfunction

  function automatic logic [20:0] ev(logic o, logic [1:0] b, logic [1:0] p, logic d,
                                     logic [14:0] c);
    return {o, b, p, d, c};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clock) rd_pend <= rd_en & rst_b;

  // Monitor: each read strobe yields exactly one rd_data word one cycle later.
  always @(negedge clock) begin
    if (rd_pend === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected: got %0h expected no read", rd_data);
      end else begin
        logic [20:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          failures++;
          $display("FAIL rd_data: got %0h expected %0h", rd_data, e);
        end
`ifdef BG_SECOND_LAYER_EN
        e = exp2_q.pop_front();
        checks++;
        if (rd_second !== e) begin
          failures++;
          $display("FAIL rd_second: got %0h expected %0h", rd_second, e);
        end
`endif
      end
    end
  end

  task automatic idle();
    @(negedge clock);
    bg_packet = '0;
    hcount    = 8'hFF;
    row_start = 1'b0;
    swap      = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
  endtask

  task automatic rd(logic [7:0] a, logic [20:0] e, logic [20:0] e2);
    idle();
    rd_en   = 1'b1;
    rd_addr = a;
    exp_q.push_back(e);
    exp2_q.push_back(e2);
  endtask

  task automatic group(logic [7:0] hc, logic [19:0] p0, logic [19:0] p1, logic [19:0] p2,
                       logic [19:0] p3, logic sw3, logic rd3, logic [7:0] ra,
                       logic [20:0] e, logic [20:0] e2);
    logic [19:0] p [4];
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      bg_packet = p[i];
      hcount    = hc;
      row_start = (i == 0);
      swap      = (i == 3) && sw3;
      rd_en     = (i == 3) && rd3;
      rd_addr   = ra;
      if ((i == 3) && rd3) begin
        exp_q.push_back(e);
        exp2_q.push_back(e2);
      end
    end
  endtask

  task automatic do_swap();
    idle();
    swap = 1'b1;
    idle();
    chk("line_ready_pulse", 32'(line_ready), 32'd1);
    chk("wr_count_swap", 32'(wr_count), 32'd0);
    idle();
    chk("line_ready_drop", 32'(line_ready), 32'd0);
  endtask

  logic [20:0] w3, s3, w5, s5, w7, w8, s8, w10, np;

  initial begin
    w3  = ev(1, 2, 1, 0, 15'h7ABC); s3 = ev(1, 1, 2, 0, 15'h0123);
    w5  = ev(1, 0, 0, 1, 15'h0AAA); s5 = ev(1, 3, 0, 0, 15'h0CCC);
    w7  = ev(1, 0, 3, 0, 15'h1234);
    w8  = ev(1, 1, 0, 0, 15'h0111); s8 = ev(1, 2, 3, 1, 15'h0222);
    w10 = ev(1, 0, 1, 0, 15'h0A0A);
    np  = pk(0, 0, 0, 0, 15'h0);
    rst_b = 1'b0;
    bg_packet = '0; hcount = 8'hFF; row_start = 0; swap = 0; rd_en = 0; rd_addr = '0;
    repeat (3) @(negedge clock);
    rst_b = 1'b1;
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    chk("reset_wr_count", 32'(wr_count), 32'd0);
    chk("reset_line_ready", 32'(line_ready), 32'd0);
    rd(8'd5, 21'd0, 21'd0);

    group(8'd3, pk(1, 1, 0, 0, 15'h1111), pk(1, 0, 2, 0, 15'h0123), pk(1, 0, 1, 0, 15'h7ABC),
          pk(0, 0, 0, 0, 15'h5555), 0, 0, 8'd0, 21'd0, 21'd0);
    idle();
    chk("wr_count_col3", 32'(wr_count), 32'd1);
    do_swap();
    rd(8'd3, w3, s3);
    rd(8'd4, 21'd0, 21'd0);

    group(8'd5, pk(1, 0, 0, 1, 15'h0AAA), np, pk(1, 0, 2, 0, 15'h0BBB),
          pk(1, 0, 0, 0, 15'h0CCC), 0, 0, 8'd0, 21'd0, 21'd0);
    group(8'd250, pk(1, 0, 1, 0, 15'h0001), pk(1, 0, 0, 0, 15'h0002), np, np,
          0, 0, 8'd0, 21'd0, 21'd0);
    idle();
    chk("wr_count_hcount_250", 32'(wr_count), 32'd1);
    group(8'd6, pk(1, 1, 0, 0, 15'h0006), pk(1, 1, 1, 0, 15'h0006), pk(0, 1, 0, 0, 15'h0),
          pk(1, 1, 2, 0, 15'h0006), 0, 0, 8'd0, 21'd0, 21'd0);
    group(8'd8, np, pk(1, 0, 0, 0, 15'h0111), pk(1, 0, 3, 1, 15'h0222),
          pk(1, 1, 0, 0, 15'h0333), 0, 0, 8'd0, 21'd0, 21'd0);
    idle();
    chk("wr_count_col8", 32'(wr_count), 32'd3);

    // Commit at col 7 coincides with swap; read in that cycle sees the pre-swap read bank.
    group(8'd7, pk(1, 0, 3, 0, 15'h1234), np, np, np, 1, 1, 8'd3, w3, s3);
    idle();
    chk("line_ready_commit_swap", 32'(line_ready), 32'd1);
    chk("wr_count_commit_swap", 32'(wr_count), 32'd0);
    idle();
    chk("line_ready_one_cycle", 32'(line_ready), 32'd0);
    rd(8'd5, w5, s5);
    rd(8'd6, 21'd0, 21'd0);
    rd(8'd8, w8, s8);
    rd(8'd3, 21'd0, 21'd0);
    rd(8'd250, 21'd0, 21'd0);
    rd(8'd7, w7, 21'd0);
    idle();
    idle();
    chk("rd_data_hold", 32'(rd_data), 32'(w7));

    // Col 9 abandoned by a row_start at its phase 2.
    @(negedge clock);
    bg_packet = pk(1, 0, 0, 0, 15'h0999); hcount = 8'd9; row_start = 1;
    @(negedge clock);
    bg_packet = pk(1, 0, 1, 0, 15'h0998); row_start = 0;
    group(8'd10, pk(1, 0, 1, 0, 15'h0A0A), np, np, np, 0, 0, 8'd0, 21'd0, 21'd0);
    idle();
    chk("wr_count_abandon", 32'(wr_count), 32'd1);
    do_swap();
    rd(8'd9, 21'd0, 21'd0);
    rd(8'd10, w10, 21'd0);
    rd(8'd3, 21'd0, 21'd0);
    idle();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
